two_pulses_gen: RTL and testbench
=================================

TWO_PULSES_GEN -- requirements
Module: two_pulses_gen

Interface
REQ-001 SHALL have parameter: GAP_W, 4, width of the inter-pulse gap field.
REQ-002 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start_i  input  1  request to emit one sequence; sampled only while ready_o=1.
REQ-005 SHALL have port: y_cnt_i  input  2  number of y pulses (0..3) between the two x pulses; captured on acceptance.
REQ-006 SHALL have port: gap_i  input  GAP_W  idle cycles between consecutive pulses; captured on acceptance.
REQ-007 SHALL have port: term_i  input  1  append one terminating y pulse after the second x; captured on acceptance.
REQ-008 SHALL have port: abort_i  input  1  cancel the sequence in progress.
REQ-009 SHALL have port: x_o  output  1  x pulse, one cycle wide, registered.
REQ-010 SHALL have port: y_o  output  1  y pulse, one cycle wide, registered.
REQ-011 SHALL have port: ready_o  output  1  high when idle and able to accept start_i.
REQ-012 SHALL have port: done_o  output  1  one-cycle completion strobe, registered.

Function
REQ-013 SHALL accept a request on a clock edge where start_i=1 and ready_o=1, latching y_cnt_i, gap_i and term_i.
REQ-014 SHALL ignore start_i and input-field changes while ready_o=0.
REQ-015 SHALL implement states IDLE, XFIRST, GAP, YPULSE, XLAST, YTERM.
REQ-016 SHALL enter XFIRST on acceptance, driving x_o=1 in the first cycle after the acceptance edge (latency 1).
REQ-017 SHALL leave every pulse state after exactly one cycle, for a single-cycle pulse.
REQ-018 SHALL insert exactly G latched-gap cycles with x_o=y_o=0 after every pulse except the final one; G=0 gives back-to-back pulses.
REQ-019 SHALL emit, in order: one x; N latched y pulses; one x; then one y only if term was latched.
REQ-020 SHALL go directly from XFIRST (through GAP) to XLAST when N=0.
REQ-021 SHALL keep a pulse counter of 2 bits and a gap down-counter of GAP_W bits; neither counter may wrap.
REQ-022 SHALL never assert x_o and y_o in the same cycle.
REQ-023 SHALL assert done_o for one cycle, and raise ready_o, in the cycle immediately after the final pulse.
REQ-024 SHALL allow a new start_i to be accepted in the same cycle done_o is high, with the next x_o one cycle later.
REQ-025 SHALL force a return to IDLE on a clock edge with abort_i=1 and state not IDLE: x_o=y_o=0 and ready_o=1 next cycle, no done_o.
REQ-026 SHALL give abort_i no effect in IDLE; if abort_i and start_i are both 1 in IDLE, the start is accepted.
REQ-027 SHALL make ready_o a function of state only (high in IDLE), so it does not depend combinationally on start_i.
REQ-028 SHALL produce a sequence that causes the paired two-pulse detector to assert its output on the second x exactly when N=2; when term=1, that output is cleared by the terminating y.

Reset
REQ-029 SHALL, with reset=1 on a clock edge, go to IDLE and clear all latched fields and counters.
REQ-030 SHALL drive the following outputs in the cycle after a reset edge: x_o=0, y_o=0, done_o=0, ready_o=1.
REQ-031 SHALL give reset priority over start_i and abort_i, and SHALL discard a sequence in progress with no done_o.

Verification
REQ-032 SHALL check, with N=2, G=1, term=0 and start accepted at edge 0: x_o at cycles 1 and 7; y_o at cycles 3 and 5; done_o at cycle 8; detector output high from cycle 7.
REQ-033 SHALL check, with N=2, G=0, term=1: x at cycle 1; y at cycles 2 and 3; x at cycle 4; y at cycle 5; done at cycle 6; detector output high at cycle 4 and low at cycle 5.
REQ-034 SHALL check, with N=3, G=2, term=0: x at cycles 1 and 13; y at cycles 4, 7 and 10; done at cycle 14; detector output never high.
REQ-035 SHALL check, with N=0, G=0: x at cycles 1 and 2; done at cycle 3; a second start at cycle 3 gives x at cycle 4.
REQ-036 SHALL check that abort_i at cycle 4 of the REQ-032 sequence gives no further pulses, ready_o=1 at cycle 5 and no done_o; and that start_i held high while busy is ignored.
REQ-037 SHALL check that reset asserted mid-sequence gives outputs 0 and ready_o=1 the next cycle, and that a following start begins a clean sequence.

Source files
------------

// File: rtl/two_pulses_gen.sv
// Two-pulse sequence generator. It emits an x pulse, N y pulses and a second x pulse,
// optionally followed by a terminating y pulse, with a programmable idle gap between pulses.
module two_pulses_gen #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       y_cnt_i,
  input  logic [GAP_W-1:0] gap_i,
  input  logic             term_i,
  input  logic             abort_i,
  output logic             x_o,
  output logic             y_o,
  output logic             ready_o,
  output logic             done_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    XFIRST = 3'd1,
    GAP    = 3'd2,
    YPULSE = 3'd3,
    XLAST  = 3'd4,
    YTERM  = 3'd5
  } state_t;

  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state_q, state_d;
  state_t           nxt_q, nxt_d;
  state_t           follow;
  logic             adv;
  logic [1:0]       pcnt_q, pcnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic             term_q, term_d;
  logic             done_d;
  logic             x_q, y_q, done_q;

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    pcnt_d  = pcnt_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    term_d  = term_q;
    done_d  = 1'b0;
    follow  = IDLE;
    adv     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = XFIRST;
          pcnt_d  = y_cnt_i;
          gap_d   = gap_i;
          term_d  = term_i;
        end
      end
      XFIRST: begin
        follow = (pcnt_q != 2'd0) ? YPULSE : XLAST;
        adv    = 1'b1;
      end
      YPULSE: begin
        // pcnt_q counts the y pulses still owed, including this one
        if (pcnt_q != 2'd0) pcnt_d = pcnt_q - 2'd1;
        follow = (pcnt_q > 2'd1) ? YPULSE : XLAST;
        adv    = 1'b1;
      end
      XLAST: begin
        if (term_q) begin
          follow = YTERM;
          adv    = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      YTERM: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      GAP: begin
        if (gcnt_q == '0) state_d = nxt_q;
        else              gcnt_d  = gcnt_q - GAP_ONE;
      end
      default: state_d = IDLE;
    endcase

    // A non-final pulse either chains straight into the next one or parks in GAP
    if (adv) begin
      if (gap_q == '0) begin
        state_d = follow;
      end else begin
        state_d = GAP;
        gcnt_d  = gap_q - GAP_ONE;
        nxt_d   = follow;
      end
    end

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nxt_q   <= IDLE;
      pcnt_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      term_q  <= 1'b0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      pcnt_q  <= pcnt_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      term_q  <= term_d;
      x_q     <= (state_d == XFIRST) || (state_d == XLAST);
      y_q     <= (state_d == YPULSE) || (state_d == YTERM);
      done_q  <= done_d;
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign done_o  = done_q;
  assign ready_o = (state_q == IDLE);

endmodule

// File: tb/tb_two_pulses_gen.sv
// Bench for two_pulses_gen: directed sequences with fixed cycle masks, then random traffic
// compared against a queue-based model of the expected output stream.
module tb_two_pulses_gen;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_i = 1'b0;
  logic [1:0]       y_cnt_i = '0;
  logic [GAP_W-1:0] gap_i = '0;
  logic             term_i = 1'b0;
  logic             abort_i = 1'b0;
  logic             x_o, y_o, ready_o, done_o;

  two_pulses_gen #(.GAP_W(GAP_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .y_cnt_i (y_cnt_i),
    .gap_i   (gap_i),
    .term_i  (term_i),
    .abort_i (abort_i),
    .x_o     (x_o),
    .y_o     (y_o),
    .ready_o (ready_o),
    .done_o  (done_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected per-cycle outputs, packed as {ready, done, x, y}
  logic [3:0]  q[$];
  logic [3:0]  cur = 4'b1000;
  logic [31:0] xm, ym, dm, rm, detm;
  logic        det;
  int          ycnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void push_seq(input int n, input int g, input bit t);
    int np;
    np = n + 2 + (t ? 1 : 0);
    for (int i = 0; i < np; i++) begin
      q.push_back((i == 0 || i == n + 1) ? 4'b0010 : 4'b0001);
      if (i != np - 1)
        for (int k = 0; k < g; k++) q.push_back(4'b0000);
    end
    q.push_back(4'b1100);
  endfunction

  task automatic step(input logic st, input logic [1:0] yc, input logic [GAP_W-1:0] gp,
                      input logic tm, input logic ab, input logic rs);
    start_i = st; y_cnt_i = yc; gap_i = gp; term_i = tm; abort_i = ab; reset = rs;
    if (rs) begin
      q.delete();
    end else if (!cur[3]) begin
      if (ab) q.delete();
    end else if (st) begin
      push_seq(int'(yc), int'(gp), tm);
    end
    cur = (q.size() != 0) ? q.pop_front() : 4'b1000;
    @(posedge clk);
    @(negedge clk);
    chk("x", 32'(x_o), 32'(cur[1]));
    chk("y", 32'(y_o), 32'(cur[0]));
    chk("done", 32'(done_o), 32'(cur[2]));
    chk("ready", 32'(ready_o), 32'(cur[3]));
    chk("x_y_excl", 32'(x_o & y_o), 32'd0);
  endtask

  // Runs 16 edges; edge 0 accepts the request, cycle k is the sample after edge k-1
  task automatic run_seq(input int n, input int g, input bit t, input int ab_at,
                         input int rs_at, input int re_at, input bit hold);
    logic             st, tm;
    logic [1:0]       yc;
    logic [GAP_W-1:0] gp;
    xm = '0; ym = '0; dm = '0; rm = '0; detm = '0; det = 1'b0; ycnt = 0;
    for (int c = 0; c < 16; c++) begin
      st = (c == 0) || (c == re_at) || (hold && c > 0 && c < ab_at);
      if (st) begin
        yc = 2'(n); gp = GAP_W'(g); tm = t;
      end else begin
        yc = 2'($urandom); gp = GAP_W'($urandom); tm = 1'($urandom);
      end
      step(st, yc, gp, tm, c == ab_at, c == rs_at);
      xm[c+1] = x_o; ym[c+1] = y_o; dm[c+1] = done_o; rm[c+1] = ready_o;
      // Detector: fires on an x that follows exactly two y pulses, cleared by any y
      if (x_o) begin
        det = (ycnt == 2); ycnt = 0;
      end else if (y_o) begin
        det = 1'b0; ycnt++;
      end
      detm[c+1] = det;
    end
  endtask

  initial begin
    step(1'b0, 2'd3, 4'd5, 1'b1, 1'b1, 1'b1);
    step(1'b1, 2'd2, 4'd1, 1'b0, 1'b0, 1'b1);

    run_seq(2, 1, 1'b0, -1, -1, -1, 1'b0);
    chk("n2g1_x", xm, 32'h0000_0082);
    chk("n2g1_y", ym, 32'h0000_0028);
    chk("n2g1_done", dm, 32'h0000_0100);
    chk("n2g1_ready", rm, 32'h0001_FF00);
    chk("n2g1_det", detm, 32'h0001_FF80);

    run_seq(2, 0, 1'b1, -1, -1, -1, 1'b0);
    chk("n2g0t_x", xm, 32'h0000_0012);
    chk("n2g0t_y", ym, 32'h0000_002C);
    chk("n2g0t_done", dm, 32'h0000_0040);
    chk("n2g0t_det", detm, 32'h0000_0010);

    run_seq(3, 2, 1'b0, -1, -1, -1, 1'b0);
    chk("n3g2_x", xm, 32'h0000_2002);
    chk("n3g2_y", ym, 32'h0000_0490);
    chk("n3g2_done", dm, 32'h0000_4000);
    chk("n3g2_det", detm, 32'h0000_0000);

    run_seq(0, 0, 1'b0, -1, -1, 3, 1'b0);
    chk("n0_x", xm, 32'h0000_0036);
    chk("n0_y", ym, 32'h0000_0000);
    chk("n0_done", dm, 32'h0000_0048);
    chk("n0_ready", rm, 32'h0001_FFC8);

    run_seq(2, 1, 1'b0, 4, -1, -1, 1'b1);
    chk("abort_x", xm, 32'h0000_0002);
    chk("abort_y", ym, 32'h0000_0008);
    chk("abort_done", dm, 32'h0000_0000);
    chk("abort_ready", rm, 32'h0001_FFE0);

    run_seq(3, 2, 1'b0, -1, 5, -1, 1'b0);
    chk("rst_x", xm, 32'h0000_0002);
    chk("rst_y", ym, 32'h0000_0010);
    chk("rst_done", dm, 32'h0000_0000);
    chk("rst_ready", rm, 32'h0001_FFC0);

    run_seq(2, 1, 1'b0, -1, -1, -1, 1'b0);
    chk("clean_x", xm, 32'h0000_0082);
    chk("clean_y", ym, 32'h0000_0028);
    chk("clean_done", dm, 32'h0000_0100);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, 2'($urandom), GAP_W'($urandom_range(0, 5)),
           1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 49) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
